operand_stream_tx: RTL and testbench

// Transmit side of the compute core's operand interface: buffers operand sets (a,b,c,d) written over a

---
 rtl/operand_stream_tx_pkg.sv | 39 +++
 rtl/operand_stream_tx_if.sv | 14 +
 rtl/operand_stream_tx_fifo.sv | 66 ++++++
 rtl/operand_stream_tx.sv | 161 ++++++++++++++++
 tb/tb_operand_stream_tx.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_stream_tx_pkg.sv
// Shared types and constants for the operand stream transmitter.
// Operand width here must match the DATA_WIDTH used on the top.
package operand_tx_pkg;

    localparam int          DATA_WIDTH = 32;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        GAP  = 2'b10,
        DONE = 2'b11
    } tx_state_e;

    typedef enum logic [1:0] {
        MODE_B2B  = 2'b00,
        MODE_LFSR = 2'b01,
        MODE_GAP  = 2'b10,
        MODE_RSVD = 2'b11
    } tx_mode_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [DATA_WIDTH-1:0] c;
        logic [DATA_WIDTH-1:0] d;
    } operand_set_t;

    // Galois LFSR, right-shifting: feedback bit is the outgoing LSB.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    // The reserved encoding behaves as back-to-back.
    function automatic tx_mode_e decode_mode(input logic [1:0] m);
        return (m == 2'b11) ? MODE_B2B : tx_mode_e'(m);
    endfunction

endpackage

// File: rtl/operand_stream_tx_if.sv
// Ready/valid operand-set port: master drives a..d/valid, slave drives ready.
interface operand_stream_tx_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] c;
    logic [DATA_WIDTH-1:0] d;
    logic                  valid;
    logic                  ready;

    modport master (output a, b, c, d, valid, input ready);
    modport slave  (input a, b, c, d, valid, output ready);
endinterface

// File: rtl/operand_stream_tx_fifo.sv
// Synchronous FIFO of operand sets with registered read data.
// Push when full and pop when empty are ignored.
module operand_fifo
    import operand_tx_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  operand_set_t wr_data_i,
    output logic         full_o,
    input  logic         pop_i,
    output logic         empty_o,
    output operand_set_t rd_data_o
);
    localparam int AW = $clog2(DEPTH);

    operand_set_t mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    operand_set_t rd_data_q, rd_data_d;
    logic         full, empty, do_push, do_pop;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign full_o    = full;
    assign empty_o   = empty;
    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/operand_stream_tx.sv
// Operand stream transmitter: buffers operand sets and issues a programmed
// number of them to the core with back-to-back, fixed-gap or LFSR pacing.
module operand_stream_tx #(
    parameter int          DATA_WIDTH = 32,
    parameter int          FIFO_DEPTH = 8,
    parameter int          CNT_WIDTH  = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    operand_stream_tx_if.slave    s_if,
    input  logic [1:0]            cfg_mode_i,
    input  logic [3:0]            cfg_gap_i,
    input  logic [CNT_WIDTH-1:0]  cfg_count_i,
    input  logic                  start_i,
    output logic [DATA_WIDTH-1:0] a_o,
    output logic [DATA_WIDTH-1:0] b_o,
    output logic [DATA_WIDTH-1:0] c_o,
    output logic [DATA_WIDTH-1:0] d_o,
    output logic                  a_valid_o,
    output logic                  b_valid_o,
    output logic                  c_valid_o,
    output logic                  d_valid_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CNT_WIDTH-1:0]  sent_cnt_o
);
    import operand_tx_pkg::*;

    localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    tx_state_e            state_q, state_d;
    tx_mode_e             mode_q, mode_d;
    logic [3:0]           gap_q, gap_d;
    logic [3:0]           gap_cnt_q, gap_cnt_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] sent_q, sent_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;

    operand_set_t         fifo_wr, fifo_rd;
    logic                 fifo_full, fifo_empty;
    logic                 issue_ok, pop;

    always_comb begin
        fifo_wr   = '0;
        fifo_wr.a = s_if.a;
        fifo_wr.b = s_if.b;
        fifo_wr.c = s_if.c;
        fifo_wr.d = s_if.d;
    end

    operand_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_i   (s_if.valid),
        .wr_data_i(fifo_wr),
        .full_o   (fifo_full),
        .pop_i    (pop),
        .empty_o  (fifo_empty),
        .rd_data_o(fifo_rd)
    );

    assign s_if.ready = !fifo_full;

    always_comb begin
        issue_ok = (mode_q == MODE_LFSR) ? lfsr_q[0] : 1'b1;
        pop      = (state_q == RUN) && (sent_q != count_q) && !fifo_empty && issue_ok;
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        gap_d     = gap_q;
        gap_cnt_d = gap_cnt_q;
        count_d   = count_q;
        sent_d    = sent_q;
        done_d    = done_q;
        valid_d   = 1'b0;
        lfsr_d    = lfsr_next(lfsr_q);

        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    mode_d  = decode_mode(cfg_mode_i);
                    gap_d   = cfg_gap_i;
                    count_d = cfg_count_i;
                    sent_d  = '0;
                    done_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Only reachable with sent==count when a zero-length run was started.
                if (sent_q == count_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (pop) begin
                    valid_d = 1'b1;
                    sent_d  = sent_q + CNT_WIDTH'(1);
                    if (sent_q + CNT_WIDTH'(1) == count_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (mode_q == MODE_GAP && gap_q != 4'd0) begin
                        state_d   = GAP;
                        gap_cnt_d = gap_q;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q <= 4'd1) begin
                    state_d = RUN;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            mode_q    <= MODE_B2B;
            gap_q     <= '0;
            gap_cnt_q <= '0;
            count_q   <= '0;
            sent_q    <= '0;
            lfsr_q    <= SEED_EFF;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            gap_q     <= gap_d;
            gap_cnt_q <= gap_cnt_d;
            count_q   <= count_d;
            sent_q    <= sent_d;
            lfsr_q    <= lfsr_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    // The FIFO read register doubles as the data output register and holds between issues.
    assign a_o        = fifo_rd.a;
    assign b_o        = fifo_rd.b;
    assign c_o        = fifo_rd.c;
    assign d_o        = fifo_rd.d;
    assign a_valid_o  = valid_q;
    assign b_valid_o  = valid_q;
    assign c_valid_o  = valid_q;
    assign d_valid_o  = valid_q;
    assign busy_o     = (state_q == RUN) || (state_q == GAP);
    assign done_o     = done_q;
    assign sent_cnt_o = sent_q;

endmodule

// File: tb/tb_operand_stream_tx.sv
// Directed and randomized checks of operand_stream_tx against a queue/LFSR reference model.
module tb_operand_stream_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cfg_mode;
    logic [3:0]  cfg_gap;
    logic [15:0] cfg_count;
    logic        start;
    logic [31:0] a_o, b_o, c_o, d_o;
    logic        a_valid_o, b_valid_o, c_valid_o, d_valid_o;
    logic        busy_o, done_o;
    logic [15:0] sent_cnt_o;

    operand_stream_tx_if #(.DATA_WIDTH(32)) s_if ();

    operand_stream_tx #(
        .DATA_WIDTH(32),
        .FIFO_DEPTH(8),
        .CNT_WIDTH (16),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .s_if       (s_if.slave),
        .cfg_mode_i (cfg_mode),
        .cfg_gap_i  (cfg_gap),
        .cfg_count_i(cfg_count),
        .start_i    (start),
        .a_o        (a_o),
        .b_o        (b_o),
        .c_o        (c_o),
        .d_o        (d_o),
        .a_valid_o  (a_valid_o),
        .b_valid_o  (b_valid_o),
        .c_valid_o  (c_valid_o),
        .d_valid_o  (d_valid_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .sent_cnt_o (sent_cnt_o)
    );

    always #5 clk = ~clk;

    // Reference LFSR: runs every cycle outside reset, independent of the DUT.
    logic [15:0] m_lfsr;
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= (m_lfsr >> 1) ^ ((m_lfsr % 2 == 1) ? 16'hB400 : 16'h0000);
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [127:0] exp_q[$];
    logic [127:0] issued_data[$];
    int           issue_cyc[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1ns after the edge and score any issued set against the model queue.
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        if (a_valid_o || b_valid_o || c_valid_o || d_valid_o) begin
            check("valids_together", {a_valid_o, b_valid_o, c_valid_o, d_valid_o}, 4'hF);
            check("issue_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("issue_data", {a_o, b_o, c_o, d_o}, exp_q.pop_front());
            issue_cyc.push_back(cyc);
            issued_data.push_back({a_o, b_o, c_o, d_o});
        end
    endtask

    task automatic push_set(input logic [127:0] s);
        bit acc = 1'b0;
        {s_if.a, s_if.b, s_if.c, s_if.d} = s;
        s_if.valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            acc = s_if.ready;
            cycle();
            if (acc) break;
        end
        s_if.valid = 1'b0;
        check("push_accepted", acc, 1'b1);
        if (acc) exp_q.push_back(s);
    endtask

    task automatic start_run(input logic [1:0] mode, input logic [3:0] gap, input logic [15:0] cnt);
        cfg_mode  = mode;
        cfg_gap   = gap;
        cfg_count = cnt;
        start     = 1'b1;
        cycle();
        start     = 1'b0;
        cfg_count = 16'hFFFF;   // must have been latched already
        cfg_gap   = 4'hF;
    endtask

    task automatic wait_done(input string tag, input int max);
        for (int k = 0; k < max && !done_o; k++) cycle();
        check(tag, done_o, 1'b1);
    endtask

    function automatic logic [127:0] rnd_set();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int c0, q, rem, t0;
        bit pred, acc;
        logic [127:0] s9, s_new;
        logic [31:0] fa, fb, fc, fd;

        rst = 1'b1; start = 1'b0; cfg_mode = '0; cfg_gap = '0; cfg_count = '0;
        s_if.valid = 1'b0; s_if.a = '0; s_if.b = '0; s_if.c = '0; s_if.d = '0;
        repeat (3) cycle();
        rst = 1'b0;

        // 1: reset state, then a reset in the middle of a run
        check("t1_rst_valid", {a_valid_o, b_valid_o, c_valid_o, d_valid_o}, 4'h0);
        check("t1_rst_data", {a_o, b_o, c_o, d_o}, 128'h0);
        check("t1_rst_ready", s_if.ready, 1'b1);
        check("t1_rst_busy_done", {busy_o, done_o}, 2'b00);
        check("t1_rst_sent", sent_cnt_o, 16'd0);
        start_run(2'b00, 4'd0, 16'd5);
        push_set(rnd_set());
        push_set(rnd_set());
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        exp_q.delete();
        check("t1_mid_valid", {a_valid_o, b_valid_o, c_valid_o, d_valid_o}, 4'h0);
        check("t1_mid_data", {a_o, b_o, c_o, d_o}, 128'h0);
        check("t1_mid_ready", s_if.ready, 1'b1);
        check("t1_mid_busy_done", {busy_o, done_o}, 2'b00);

        // 2: mode 00, count 5, minimum latency and q of the first set
        issue_cyc.delete(); issued_data.delete();
        start_run(2'b00, 4'd0, 16'd5);
        push_set({32'd10, 32'd4, 32'd2, 32'd1});
        c0 = cyc;
        for (int i = 0; i < 4; i++) push_set(rnd_set());
        wait_done("t2_done_timeout", 30);
        check("t2_issue_count", issue_cyc.size(), 5);
        for (int i = 0; i < 5 && i < issue_cyc.size(); i++)
            check("t2_issue_cycle", issue_cyc[i], c0 + 1 + i);
        if (issued_data.size() != 0) begin
            fa = issued_data[0][127:96]; fb = issued_data[0][95:64];
            fc = issued_data[0][63:32];  fd = issued_data[0][31:0];
            q = ((int'(fa) - int'(fb)) * (1 + 3 * int'(fc)) - 4 * int'(fd)) / 2;
            check("t2_q_first", q, 19);
        end
        check("t2_sent", sent_cnt_o, 16'd5);
        check("t2_busy", busy_o, 1'b0);

        // 3: fill to full, hold the 9th, then drain nine in order
        for (int i = 0; i < 8; i++) push_set(rnd_set());
        check("t3_full_ready", s_if.ready, 1'b0);
        s9 = rnd_set();
        {s_if.a, s_if.b, s_if.c, s_if.d} = s9;
        s_if.valid = 1'b1;
        repeat (3) begin
            check("t3_held_ready", s_if.ready, 1'b0);
            cycle();
        end
        issue_cyc.delete();
        cfg_mode = 2'b00; cfg_count = 16'd9; start = 1'b1;
        acc = s_if.ready;
        cycle();
        start = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            acc = s_if.ready;
            cycle();
        end
        s_if.valid = 1'b0;
        check("t3_ninth_accepted", acc, 1'b1);
        if (acc) exp_q.push_back(s9);
        wait_done("t3_done_timeout", 40);
        check("t3_issue_count", issue_cyc.size(), 9);
        check("t3_sent", sent_cnt_o, 16'd9);
        check("t3_model_drained", exp_q.size(), 0);

        // 4: mode 10 gap 3 -> pulses four cycles apart; start during the run is ignored
        for (int i = 0; i < 3; i++) push_set(rnd_set());
        issue_cyc.delete();
        start_run(2'b10, 4'd3, 16'd3);
        for (int k = 0; k < 20 && issue_cyc.size() < 1; k++) cycle();
        cfg_count = 16'd7; start = 1'b1;
        cycle();
        start = 1'b0;
        check("t4_restart_ignored_sent", sent_cnt_o, 16'd1);
        check("t4_restart_ignored_busy", {busy_o, done_o}, 2'b10);
        wait_done("t4_done_timeout", 40);
        repeat (3) cycle();
        check("t4_issue_count", issue_cyc.size(), 3);
        for (int i = 1; i < 3 && i < issue_cyc.size(); i++)
            check("t4_spacing", issue_cyc[i] - issue_cyc[i-1], 4);
        check("t4_sent", sent_cnt_o, 16'd3);

        // 5: mode 01, count 20, issue cycles follow the reference LFSR bit-exactly
        for (int i = 0; i < 8; i++) push_set(rnd_set());
        start_run(2'b01, 4'd0, 16'd20);
        rem = 20;
        for (int k = 0; k < 300 && rem > 0; k++) begin
            pred = m_lfsr[0];
            if (pred) rem--;
            acc = s_if.ready;
            if (acc) begin
                s_new = rnd_set();
                {s_if.a, s_if.b, s_if.c, s_if.d} = s_new;
            end
            s_if.valid = acc;
            cycle();
            if (acc) exp_q.push_back(s_new);
            check("t5_lfsr_issue", a_valid_o, pred);
        end
        s_if.valid = 1'b0;
        check("t5_all_issued", rem, 0);
        check("t5_done", done_o, 1'b1);
        check("t5_sent", sent_cnt_o, 16'd20);
        t0 = issue_cyc.size();
        start_run(2'b00, 4'd0, 16'd0);
        check("t5_zero_run_state", {busy_o, done_o}, 2'b10);
        cycle();
        check("t5_zero_done", {busy_o, done_o}, 2'b01);
        repeat (3) cycle();
        check("t5_zero_no_issue", issue_cyc.size() - t0, 0);
        check("t5_zero_sent", sent_cnt_o, 16'd0);

        // 6: reset after two of five issues, then a fresh run
        rst = 1'b1; cycle(); rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 5; i++) push_set(rnd_set());
        issue_cyc.delete();
        start_run(2'b00, 4'd0, 16'd5);
        for (int k = 0; k < 20 && issue_cyc.size() < 2; k++) cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        exp_q.delete();
        check("t6_valid_after_rst", {a_valid_o, b_valid_o, c_valid_o, d_valid_o}, 4'h0);
        check("t6_sent_after_rst", sent_cnt_o, 16'd0);
        check("t6_ready_after_rst", s_if.ready, 1'b1);
        t0 = issue_cyc.size();
        start_run(2'b00, 4'd0, 16'd1);
        repeat (4) cycle();
        check("t6_fifo_empty_no_issue", issue_cyc.size() - t0, 0);
        check("t6_waiting_busy", busy_o, 1'b1);
        s_new = rnd_set();
        push_set(s_new);
        wait_done("t6_done_timeout", 20);
        check("t6_new_issue_count", issue_cyc.size() - t0, 1);
        if (issued_data.size() != 0) check("t6_new_data", issued_data[$], s_new);
        check("t6_sent", sent_cnt_o, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
